// File: rtl/calc_port_responder.sv
// calc_port_responder: a two-beat command port (command + operand 1, then
// operand 2) followed by a fixed LATENCY-cycle BUSY window and a single-cycle
// response carrying ADD/SUB/SLL/SRR results or an error code.
//
// Handshake: there is no valid/ready pair. A non-zero req_cmd_in sampled in
// IDLE is the request. req_data_in is taken as operand 2 on the next edge
// regardless of req_cmd_in. busy is high in every state other than IDLE,
// and any command seen while busy is dropped. out_resp is non-zero for
// exactly one cycle, and only in RESP.
module calc_port_responder #(
  parameter int unsigned LATENCY = 3
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req_cmd_in,
  input  logic [0:31] req_data_in,
  output logic [0:1]  out_resp,
  output logic [0:31] out_data,
  output logic        busy
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_ADD = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_SLL = 4'b0101;
  localparam logic [3:0] CMD_SRR = 4'b0110;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP2  = 2'd1,
    S_BUSY = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [0:31] op1_q, op1_d;
  logic [0:31] op2_q, op2_d;

  logic [32:0] sum33;
  logic [1:0]  res_code;
  logic [0:31] res_data;

  // State, counter and latched transaction; reset clears everything at once.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      cmd_q   <= CMD_NOP;
      op1_q   <= '0;
      op2_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
    end
  end

  // Next-state logic: accept in IDLE, take operand 2, count down, respond.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    case (state_q)
      S_IDLE: begin
        if (req_cmd_in != CMD_NOP) begin
          cmd_d   = req_cmd_in;
          op1_d   = req_data_in;
          state_d = S_OP2;
        end
      end
      S_OP2: begin
        op2_d   = req_data_in;
        cnt_d   = CNT_LOAD;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        // The cycle in which the counter reads 0 is the last BUSY cycle.
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Result datapath, driven only from the latched command and operands.
  always_comb begin
    sum33    = {1'b0, op1_q} + {1'b0, op2_q};
    res_code = RESP_ERR;
    res_data = '0;
    case (cmd_q)
      CMD_ADD: begin
        if (!sum33[32]) begin
          res_code = RESP_OK;
          res_data = sum33[31:0];
        end
      end
      CMD_SUB: begin
        if (op2_q <= op1_q) begin
          res_code = RESP_OK;
          res_data = op1_q - op2_q;
        end
      end
      CMD_SLL: begin
        res_code = RESP_OK;
        res_data = op1_q << op2_q[27:31];
      end
      CMD_SRR: begin
        res_code = RESP_OK;
        res_data = op1_q >> op2_q[27:31];
      end
      default: begin
        res_code = RESP_ERR;
        res_data = '0;
      end
    endcase
  end

  // Outputs: the response is visible only in RESP, and zero otherwise.
  always_comb begin
    out_resp = RESP_NONE;
    out_data = '0;
    if (state_q == S_RESP) begin
      out_resp = res_code;
      out_data = res_data;
    end
    busy = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_calc_port_responder.sv
// Self-checking bench for calc_port_responder: directed vectors, random
// transactions with interfering inputs, ignored commands, reset abort and
// minimum-spacing back-to-back traffic, all checked against a plain
// arithmetic reference model.
module tb_calc_port_responder;

  localparam int LAT = 3;

  logic        c_clk;
  logic        reset;
  logic [0:3]  req_cmd_in;
  logic [0:31] req_data_in;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  calc_port_responder #(.LATENCY(LAT)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .busy        (busy)
  );

  // Clock generation.
  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  // Reference model straight from the command rules.
  function automatic void model(input logic [3:0] cmd, input logic [31:0] a,
                                input logic [31:0] b, output logic [1:0] resp,
                                output logic [31:0] data);
    logic [63:0] s;
    resp = 2'b10;
    data = 32'd0;
    case (cmd)
      4'b0001: begin
        s = {32'd0, a} + {32'd0, b};
        if (s <= 64'h0000_0000_FFFF_FFFF) begin
          resp = 2'b01;
          data = s[31:0];
        end
      end
      4'b0010: begin
        if (b <= a) begin
          resp = 2'b01;
          data = a - b;
        end
      end
      4'b0101: begin
        resp = 2'b01;
        data = a << (b % 32);
      end
      4'b0110: begin
        resp = 2'b01;
        data = a >> (b % 32);
      end
      default: begin
        resp = 2'b10;
        data = 32'd0;
      end
    endcase
  endfunction

  // Driver: command + operand 1 now, operand 2 on the next falling edge with
  // a random command on the bus that must be ignored.
  task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    req_cmd_in  = cmd;
    req_data_in = a;
    @(negedge c_clk);
    req_cmd_in  = 4'($urandom_range(0, 15));
    req_data_in = b;
  endtask

  // Monitor: waits for a response, scrambling the inputs every busy cycle.
  // n is the number of falling edges since the command was driven, -1 on timeout.
  task automatic wait_resp(input int start, output int n, output logic [1:0] r,
                           output logic [31:0] d);
    n = -1;
    r = 2'b00;
    d = 32'd0;
    for (int i = start; i < start + 40; i++) begin
      @(negedge c_clk);
      if (out_resp != 2'b00) begin
        n = i;
        r = out_resp;
        d = out_data;
        req_cmd_in  = 4'b0000;
        req_data_in = $urandom;
        break;
      end
      req_cmd_in  = 4'($urandom_range(0, 15));
      req_data_in = $urandom;
    end
    req_cmd_in = 4'b0000;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    req_cmd_in  = 4'b0001;
    req_data_in = 32'd5;
    repeat (3) @(negedge c_clk);
    checks++;
    if (out_resp !== 2'b00 || out_data !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: resp=%b data=%h busy=%b expected 00/0/0", out_resp, out_data, busy);
    end
    reset      = 1'b1;
    req_cmd_in = 4'b0000;
    repeat (3) @(negedge c_clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_first_cmd();
    int n;
    logic [1:0] r;
    logic [31:0] d;
    reset = 1'b0;
    repeat (2) @(negedge c_clk);
    reset       = 1'b1;
    req_cmd_in  = 4'b0001;
    req_data_in = 32'd7;
    @(negedge c_clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL first_cmd_accept: busy=%b expected 1", busy);
    end
    req_cmd_in  = 4'b0000;
    req_data_in = 32'd8;
    wait_resp(2, n, r, d);
    checks++;
    if (n !== LAT + 2 || r !== 2'b01 || d !== 32'd15) begin
      errors++;
      $display("FAIL first_cmd_resp: lat=%0d resp=%b data=%h expected %0d/01/0000000f", n, r, d, LAT + 2);
    end
  endtask

  task automatic test_directed();
    logic [3:0]  c_tab[8] = '{4'b0001, 4'b0010, 4'b0010, 4'b0001, 4'b0101, 4'b0101, 4'b0110, 4'b0011};
    logic [31:0] a_tab[8] = '{32'd5, 32'd5, 32'd3, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'h8000_0000, 32'd9};
    logic [31:0] b_tab[8] = '{32'd5, 32'd5, 32'd5, 32'd1, 32'd31, 32'd32, 32'd4, 32'd9};
    logic [1:0]  r_tab[8] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
    logic [31:0] d_tab[8] = '{32'd10, 32'd0, 32'd0, 32'd0, 32'h8000_0000, 32'd1, 32'h0800_0000, 32'd0};
    int n;
    logic [1:0] r;
    logic [31:0] d;
    for (int k = 0; k < 8; k++) begin
      @(negedge c_clk);
      checks++;
      if (out_resp !== 2'b00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL dir_idle[%0d]: resp=%b busy=%b expected 00/0", k, out_resp, busy);
      end
      send(c_tab[k], a_tab[k], b_tab[k]);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL dir_busy[%0d]: busy=%b expected 1", k, busy);
      end
      wait_resp(2, n, r, d);
      checks++;
      if (n !== LAT + 2 || r !== r_tab[k] || d !== d_tab[k]) begin
        errors++;
        $display("FAIL dir_resp[%0d]: lat=%0d resp=%b data=%h expected %0d/%b/%h",
                 k, n, r, d, LAT + 2, r_tab[k], d_tab[k]);
      end
    end
    @(negedge c_clk);
    checks++;
    if (out_resp !== 2'b00 || out_data !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dir_hold: resp=%b data=%h busy=%b expected 00/0/0", out_resp, out_data, busy);
    end
  endtask

  task automatic test_random();
    logic [3:0]  cmds[5] = '{4'b0001, 4'b0010, 4'b0101, 4'b0110, 4'b1111};
    logic [3:0]  c;
    logic [31:0] a, b, ed;
    logic [1:0]  er, r;
    logic [31:0] d;
    int n;
    for (int k = 0; k < 24; k++) begin
      c = cmds[$urandom_range(0, 4)];
      if (c == 4'b1111) c = 4'($urandom_range(7, 15));
      a = (k % 6 == 0) ? 32'hFFFF_FFFF : $urandom;
      b = (k % 4 == 0) ? a : $urandom;
      if (k % 5 == 0) a = a >> $urandom_range(0, 31);
      model(c, a, b, er, ed);
      @(negedge c_clk);
      send(c, a, b);
      wait_resp(2, n, r, d);
      checks++;
      if (n !== LAT + 2 || r !== er || d !== ed) begin
        errors++;
        $display("FAIL rand_resp[%0d] cmd=%b a=%h b=%h: lat=%0d resp=%b data=%h expected %0d/%b/%h",
                 k, c, a, b, n, r, d, LAT + 2, er, ed);
      end
    end
  endtask

  task automatic test_ignore();
    int n;
    int extra;
    logic [1:0] r;
    logic [31:0] d;
    @(negedge c_clk);
    send(4'b0001, 32'd1, 32'd2);
    @(negedge c_clk);
    req_cmd_in  = 4'b0001;
    req_data_in = 32'd9;
    wait_resp(3, n, r, d);
    checks++;
    if (n !== LAT + 2 || r !== 2'b01 || d !== 32'd3) begin
      errors++;
      $display("FAIL ignore_resp: lat=%0d resp=%b data=%h expected %0d/01/00000003", n, r, d, LAT + 2);
    end
    extra = 0;
    repeat (2 * LAT + 6) begin
      @(negedge c_clk);
      if (out_resp != 2'b00 || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignore_single: extra_active_cycles=%0d expected 0", extra);
    end
  endtask

  task automatic test_reset_busy();
    int n;
    int seen;
    logic [1:0] r;
    logic [31:0] d;
    @(negedge c_clk);
    send(4'b0001, 32'd1, 32'd1);
    @(negedge c_clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_resp !== 2'b00 || out_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_async: busy=%b resp=%b data=%h expected 0/00/0", busy, out_resp, out_data);
    end
    req_cmd_in = 4'b0000;
    repeat (2) @(negedge c_clk);
    reset = 1'b1;
    seen = 0;
    repeat (2 * LAT + 6) begin
      @(negedge c_clk);
      if (out_resp != 2'b00) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_abort: response_cycles=%0d expected 0", seen);
    end
    @(negedge c_clk);
    send(4'b0001, 32'd5, 32'd5);
    wait_resp(2, n, r, d);
    checks++;
    if (n !== LAT + 2 || r !== 2'b01 || d !== 32'd10) begin
      errors++;
      $display("FAIL reset_recover: lat=%0d resp=%b data=%h expected %0d/01/0000000a", n, r, d, LAT + 2);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops[4] = '{4'b0001, 4'b0010, 4'b0101, 4'b0110};
    logic [3:0]  seq[$];
    logic [31:0] exp_q[$];
    logic [31:0] ed, d;
    logic [1:0]  er, r;
    int n;
    int got;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        seq.push_back(ops[i]);
        seq.push_back(ops[j]);
      end
    end
    foreach (seq[k]) begin
      model(seq[k], 32'd5, 32'd5, er, ed);
      exp_q.push_back(ed);
    end
    got = 0;
    foreach (seq[k]) begin
      @(negedge c_clk);
      send(seq[k], 32'd5, 32'd5);
      wait_resp(2, n, r, d);
      if (n != -1) got++;
      ed = exp_q.pop_front();
      checks++;
      if (n !== LAT + 2 || r !== 2'b01 || d !== ed) begin
        errors++;
        $display("FAIL b2b_resp[%0d] cmd=%b: lat=%0d resp=%b data=%h expected %0d/01/%h",
                 k, seq[k], n, r, d, LAT + 2, ed);
      end
    end
    checks++;
    if (got !== 32) begin
      errors++;
      $display("FAIL b2b_count: responses=%0d expected 32", got);
    end
  endtask

  initial begin
    reset       = 1'b0;
    req_cmd_in  = 4'b0000;
    req_data_in = 32'd0;
    test_reset();
    test_first_cmd();
    test_directed();
    test_random();
    test_ignore();
    test_reset_busy();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_port_responder.md
CALC_PORT_RESPONDER -- requirements
Module: calc_port_responder

Interface
REQ-001 Parameter: LATENCY, default 3, number of BUSY cycles between operand-2 capture and the response (legal 1..15).
REQ-002 Port: c_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: req_cmd_in  input  [0:3]  command: 0000 no-op, 0001 ADD, 0010 SUB, 0101 SLL, 0110 SRR, all other values invalid.
REQ-005 Port: req_data_in  input  [0:31]  operand 1 in the command cycle, operand 2 in the following cycle; bit 0 is the MSB.
REQ-006 Port: out_resp  output  [0:1]  response code: 00 none, 01 success, 10 overflow/underflow/invalid command, 11 unused.
REQ-007 Port: out_data  output  [0:31]  result; meaningful only when out_resp = 01.
REQ-008 Port: busy  output  1  high in every state except IDLE.

Function
REQ-009 The block SHALL implement the FSM IDLE -> OP2 -> BUSY -> RESP -> IDLE.
REQ-010 IDLE: when req_cmd_in != 0000, latch cmd and req_data_in as operand 1, then go to OP2.
REQ-011 OP2: latch req_data_in as operand 2 unconditionally, regardless of req_cmd_in, then go to BUSY and load the latency counter with LATENCY-1.
REQ-012 BUSY: decrement the counter each cycle and go to RESP on the cycle after the counter reads 0, so RESP is reached exactly LATENCY cycles after leaving OP2.
REQ-013 RESP: drive out_resp and out_data for exactly one cycle, then go to IDLE; out_resp = 00 and out_data = 0 in every other state.
REQ-014 Commands issued in OP2, BUSY or RESP SHALL be ignored; no queuing.
REQ-015 A command may be accepted in the IDLE cycle immediately after RESP; the minimum command-to-command spacing is LATENCY+3 cycles.
REQ-016 ADD: unsigned 33-bit sum; carry out -> resp 10 and data 0, else resp 01 with the 32-bit sum.
REQ-017 SUB: op1 - op2 unsigned; op2 > op1 -> resp 10 and data 0; op1 = op2 -> resp 01 with data 0.
REQ-018 SLL: op1 shifted left by op2[27:31] (low 5 bits); upper op2 bits are ignored; zero fill; always resp 01.
REQ-019 SRR: op1 logically shifted right by op2[27:31]; zero fill; always resp 01.
REQ-020 Invalid command: the full handshake (OP2, BUSY) is still consumed, then resp 10 with data 0.
REQ-021 The result SHALL be computed from the latched operands only; input changes after OP2 SHALL have no effect.

Reset
REQ-022 Reset assertion (reset = 0) SHALL immediately, without a clock, force state IDLE, counter 0, out_resp 00, out_data 0, busy 0, and clear the latched cmd and operands.
REQ-023 Reset asserted mid-transaction SHALL abort it silently, with no response ever produced for it.
REQ-024 The first command SHALL be accepted on the first rising edge at which reset = 1.
REQ-025 A command presented during reset SHALL be discarded.

Verification
REQ-026 LATENCY=3, ADD 5,5 -> out_resp 01, out_data 10, exactly 5 cycles after the command edge, held one cycle.
REQ-027 SUB 5,5 -> resp 01 data 0; SUB 3,5 -> resp 10 data 0; ADD FFFFFFFF,1 -> resp 10 data 0.
REQ-028 SLL 1,31 -> 80000000; SLL 1,32 -> 00000001 (low 5 bits only); SRR 80000000,4 -> 08000000.
REQ-029 Command 0011 -> resp 10 after the same latency; a new ADD issued during BUSY -> ignored, exactly one response.
REQ-030 Reset pulse in BUSY -> out_resp stays 00 and busy drops asynchronously; a following ADD 5,5 -> 10 normally.
REQ-031 The sequence ADD/SUB/SLL/SRR x ADD/SUB/SLL/SRR with operands 5,5 issued back-to-back at minimum spacing -> 32 responses, all 01, with correct data.
